bitscan_encoder: RTL
====================

# bitscan_encoder

Sequential bit-scan encoder: the encode direction for the team's one-hot decoders. Accepts a WIDTH-bit request vector over a valid/ready handshake. Emits the index of every set bit, one per output beat, in LSB-first order by default. A zero vector produces a single flagged beat. It sits between request/interrupt collectors and the index-based consumers that drive the 3-to-8 decoders.

## Interface
- WIDTH, 8, vector width; power of two, ≥2; IDX_W = $clog2(WIDTH) (localparam)
- MSB_FIRST, 0, 0 = emit lowest set index first; 1 = emit highest first
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset; deassertion synchronised externally
- in_valid  in  1  in_vec is valid
- in_ready  out  1  block can accept in_vec this cycle
- in_vec  in  WIDTH  request vector, any number of bits set
- out_valid  out  1  out_idx/out_last/out_zero valid
- out_ready  in  1  consumer accepts current beat
- out_idx  out  IDX_W  index of the current set bit; 0 when out_zero=1
- out_last  out  1  current beat is the final beat for this vector
- out_zero  out  1  accepted vector was all zeros; a single beat is emitted

## Operation
- Internal state: pending register pend[WIDTH-1:0], flag zflag, FSM state ∈ {IDLE, EMIT}.
- IDLE: out_valid=0. On in_valid&in_ready:
  - load pend=in_vec, zflag=(in_vec==0), go EMIT.
- EMIT: out_valid=1.
  - out_idx = first set bit of pend (lowest if MSB_FIRST=0, else highest); 0 if zflag.
  - out_last = zflag | (popcount(pend)==1); out_zero = zflag.
- Output handshake (out_valid&out_ready):
  - not last: clear the emitted bit in pend, stay EMIT.
  - last with in_valid: reload from in_vec, stay EMIT (back-to-back, no bubble).
  - last without in_valid: pend=0, zflag=0, go IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is the only combinational input-to-output path (out_ready→in_ready).
- in_vec is sampled only on the input handshake; changes while in EMIT are ignored.
- out_idx/out_last/out_zero hold stable while out_valid=1 and out_ready=0.
- Beats per vector = max(1, popcount(in_vec)); indices are distinct and strictly monotonic in scan order.

## Timing
- Reset (asynchronous, immediate): state=IDLE, pend=0, zflag=0; out_valid=0, out_idx=0, out_last=0, out_zero=0, in_ready=1.
- Reset mid-EMIT: the remaining beats are discarded; no beat is emitted after reset release until a new input handshake.
- Latency: vector accepted at edge N → first beat has out_valid=1 in the cycle after edge N.
- Throughput: one beat per cycle with out_ready=1. A vector with k set bits occupies k cycles. Consecutive vectors have zero gap.
- Output-side backpressure stalls indefinitely without loss.

## Structure
- bitscan_pkg holds:
  - state enum bitscan_state_t {IDLE, EMIT}.
  - WIDTH/IDX_W defaults as package constants.
- Sub-module ffs_enc (combinational, parameters WIDTH and MSB_FIRST) takes pend and produces:
  - idx: first-set index.
  - onehot: mask of that bit.
  - single: popcount==1.
- bitscan_encoder instantiates one ffs_enc. It contains the FSM, the pend/zflag registers, and the handshake logic.

## Test plan
- Reset, then in_vec=8'b0000_0100 with out_ready=1 → one beat: idx=2, last=1, zero=0. in_ready=1 in the same cycle.
- in_vec=8'b1010_0011, MSB_FIRST=0, out_ready=1 → beats idx 0,1,5,7 on consecutive cycles. last=1 only on idx 7.
  - With MSB_FIRST=1 → idx 7,5,1,0.
- in_vec=8'h00 → one beat: idx=0, zero=1, last=1.
  - in_vec=8'hFF → 8 beats, idx 0..7.
- in_vec=8'b0001_0010 with out_ready toggled 0,0,1,0,1 → idx=1 held for 3 cycles, then idx=4 held for 2 cycles. Outputs are stable under stall. in_ready=0 until the last beat is accepted.
- Two vectors 8'h01 then 8'h80 with in_valid held high → idx 0 then 7 on adjacent cycles, no bubble.
- Assert rst_n low after 2 of the 4 beats of 8'hF0 → out_valid drops immediately. After release, no stale beats appear. A new vector 8'h08 yields idx=3.

Source files
------------

// File: rtl/bitscan_pkg.sv
// Shared types and default sizing for the bit-scan encoder.
package bitscan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } bitscan_state_t;

    localparam int unsigned BITSCAN_WIDTH = 8;
    localparam int unsigned BITSCAN_IDX_W = $clog2(BITSCAN_WIDTH);

endpackage

// File: rtl/ffs_enc.sv
// Combinational find-first-set: index, one-hot mask and single-bit flag of a vector.
module ffs_enc
    import bitscan_pkg::*;
#(
    parameter int unsigned  WIDTH     = BITSCAN_WIDTH,
    parameter bit           MSB_FIRST = 1'b0,
    localparam int unsigned IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] pend_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic             single_o
);

    always_comb begin : scan
        logic found;
        idx_o    = '0;
        onehot_o = '0;
        found    = 1'b0;
        // Walk in scan order; the first hit wins and later bits are ignored.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && pend_i[IDX_W'(MSB_FIRST ? (WIDTH - 1 - i) : i)]) begin
                idx_o                  = IDX_W'(MSB_FIRST ? (WIDTH - 1 - i) : i);
                onehot_o[idx_o]        = 1'b1;
                found                  = 1'b1;
            end
        end
    end

    assign single_o = (pend_i != '0) && ((pend_i & (pend_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/bitscan_encoder.sv
// Sequential bit-scan encoder: emits the index of every set bit of an accepted
// vector, one beat per cycle, with a single flagged beat for an all-zero vector.
module bitscan_encoder
    import bitscan_pkg::*;
#(
    parameter int unsigned  WIDTH     = BITSCAN_WIDTH,
    parameter bit           MSB_FIRST = 1'b0,
    localparam int unsigned IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero
);

    bitscan_state_t   state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             zflag_q, zflag_d;

    logic [IDX_W-1:0] ffs_idx;
    logic [WIDTH-1:0] ffs_onehot;
    logic             ffs_single;
    logic             out_fire;

    ffs_enc #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_ffs (
        .pend_i   (pend_q),
        .idx_o    (ffs_idx),
        .onehot_o (ffs_onehot),
        .single_o (ffs_single)
    );

    assign out_valid = (state_q == EMIT);
    assign out_zero  = out_valid & zflag_q;
    assign out_last  = out_valid & (zflag_q | ffs_single);
    assign out_idx   = (out_valid && !zflag_q) ? ffs_idx : '0;
    assign out_fire  = out_valid & out_ready;

    // out_ready reaches in_ready combinationally so a new vector can load on the
    // same edge that retires the last beat of the current one.
    assign in_ready  = (state_q == IDLE) | (out_fire & out_last);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zflag_d = zflag_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pend_d  = in_vec;
                    zflag_d = (in_vec == '0);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (!out_last) begin
                        pend_d = pend_q & ~ffs_onehot;
                    end else if (in_valid) begin
                        pend_d  = in_vec;
                        zflag_d = (in_vec == '0);
                    end else begin
                        pend_d  = '0;
                        zflag_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                pend_d  = '0;
                zflag_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zflag_q <= zflag_d;
        end
    end

endmodule
